taillight_seq: RTL and testbench

Parametrised rear-light controller and next generation of the single-bank light controller. It drives independent left and right LED banks of LEDS_PER_SIDE lamps each. Supported functions are brake, sequential (sweeping) turn indication per side, and hazard. It sits between the driver-input conditioning logic and the LED output pins, and all outputs are registered.

---
 rtl/taillight_pkg.sv | 18 +
 rtl/step_timer.sv | 28 ++
 rtl/taillight_seq.sv | 62 ++++++
 tb/tb_taillight_seq.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/taillight_pkg.sv
// taillight_pkg: shared mode encoding and sweep-mask helper for the rear-light controller
package taillight_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LEFT   = 2'b01,
        RIGHT  = 2'b10,
        HAZARD = 2'b11
    } mode_t;

    // Phase p lights the p innermost lamps; 9-bit intermediate keeps p=8 exact
    function automatic logic [7:0] sweep_mask(input logic [3:0] p);
        logic [8:0] m;
        m = (9'd1 << p) - 9'd1;
        return m[7:0];
    endfunction

endpackage

// File: rtl/step_timer.sv
// step_timer: free-running prescaler emitting a one-cycle tick every STEP_DIV enabled cycles
module step_timer #(
    parameter int STEP_DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(STEP_DIV);

    logic [CW-1:0] cnt, cnt_nx;

    always_comb begin
        tick   = en && !clr && (cnt == CW'(STEP_DIV - 1));
        cnt_nx = (clr || !en || tick) ? '0 : cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= cnt_nx;
    end

endmodule

// File: rtl/taillight_seq.sv
// taillight_seq: left/right sequential turn, hazard and brake controller with registered LED banks
module taillight_seq
    import taillight_pkg::*;
#(
    parameter int LEDS_PER_SIDE = 3,
    parameter int STEP_DIV      = 12_500_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     brake,
    input  logic                     turn_left,
    input  logic                     turn_right,
    input  logic                     hazard,
    output logic [LEDS_PER_SIDE-1:0] led_left,
    output logic [LEDS_PER_SIDE-1:0] led_right
);

    localparam int PW = $clog2(LEDS_PER_SIDE + 1);

    mode_t                    mode, mode_nx;
    logic [PW-1:0]            phase, phase_nx;
    logic [7:0]               mask;
    logic                     chg, tick;
    logic [LEDS_PER_SIDE-1:0] left_nx, right_nx;

    step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mode != IDLE),
        .clr   (chg),
        .tick  (tick)
    );

    always_comb begin
        mode_nx  = (hazard || (turn_left && turn_right)) ? HAZARD :
                   turn_left  ? LEFT  :
                   turn_right ? RIGHT : IDLE;
        chg      = mode_nx != mode;
        phase_nx = chg   ? ((mode_nx == IDLE) ? '0 : PW'(1)) :
                   !tick ? phase :
                   (phase == PW'(LEDS_PER_SIDE)) ? '0 : phase + PW'(1);
        mask     = sweep_mask(4'(phase_nx));
        // Mode bit 0 marks a sweeping left bank, bit 1 a sweeping right bank
        left_nx  = mode_nx[0] ? mask[LEDS_PER_SIDE-1:0] : {LEDS_PER_SIDE{brake}};
        right_nx = mode_nx[1] ? mask[LEDS_PER_SIDE-1:0] : {LEDS_PER_SIDE{brake}};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode      <= IDLE;
            phase     <= '0;
            led_left  <= '0;
            led_right <= '0;
        end else begin
            mode      <= mode_nx;
            phase     <= phase_nx;
            led_left  <= left_nx;
            led_right <= right_nx;
        end
    end

endmodule

// File: tb/tb_taillight_seq.sv
// tb_taillight_seq: directed self-checking bench for taillight_seq (3 lamps, 4-cycle steps)
module tb_taillight_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       brake = 1'b0;
    logic       turn_left = 1'b0;
    logic       turn_right = 1'b0;
    logic       hazard = 1'b0;
    logic [2:0] led_left;
    logic [2:0] led_right;

    int checks = 0;
    int passed = 0;

    taillight_seq #(.LEDS_PER_SIDE(3), .STEP_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .brake      (brake),
        .turn_left  (turn_left),
        .turn_right (turn_right),
        .hazard     (hazard),
        .led_left   (led_left),
        .led_right  (led_right)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] pat(input int p);
        return 3'((1 << p) - 1);
    endfunction

    // Advance n rising edges, then settle on the falling edge for sampling and driving
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [2:0] l_exp, input logic [2:0] r_exp);
        checks++;
        assert (led_left === l_exp && led_right === r_exp) passed++;
        else $error("FAIL %s: left=%b right=%b, expected left=%b right=%b",
                    tag, led_left, led_right, l_exp, r_exp);
    endtask

    // Request edge is i=0; brake toggles every cycle and must stay invisible
    task automatic hazard_run(input string tag);
        for (int i = 0; i < 16; i++) begin
            brake = i[0];
            step(1);
            check(tag, pat((1 + i / 4) % 4), pat((1 + i / 4) % 4));
        end
    endtask

    initial begin
        @(negedge clk);
        // 1. reset with brake, then brake alone
        brake = 1'b1;
        step(3);
        check("reset", 3'b000, 3'b000);
        rst_n = 1'b1;
        step(1);
        check("brake_on", 3'b111, 3'b111);
        brake = 1'b0;
        step(1);
        check("brake_off", 3'b000, 3'b000);

        // 2. left sweep through a full period and into the next
        turn_left = 1'b1;
        step(1);
        check("left_first", 3'b001, 3'b000);
        for (int i = 1; i <= 16; i++) begin
            step(1);
            check("left_sweep", pat((1 + i / 4) % 4), 3'b000);
        end
        turn_left = 1'b0;
        step(1);
        check("left_release", 3'b000, 3'b000);

        // 3. right sweep with brake, brake dropped mid-sweep
        brake = 1'b1;
        turn_right = 1'b1;
        step(1);
        check("right_first", 3'b111, 3'b001);
        for (int i = 1; i <= 13; i++) begin
            if (i == 7) brake = 1'b0;
            step(1);
            check("right_sweep", (i >= 7) ? 3'b000 : 3'b111, pat((1 + i / 4) % 4));
        end
        turn_right = 1'b0;
        step(1);
        check("right_release", 3'b000, 3'b000);

        // 4. hazard, then both turn requests, must produce identical waveforms
        hazard = 1'b1;
        hazard_run("hazard");
        hazard = 1'b0;
        brake = 1'b0;
        step(1);
        check("hazard_release", 3'b000, 3'b000);
        turn_left = 1'b1;
        turn_right = 1'b1;
        hazard_run("both_turn");
        turn_left = 1'b0;
        turn_right = 1'b0;
        brake = 1'b0;
        step(1);
        check("both_release", 3'b000, 3'b000);

        // 5. switch left->right mid-sweep with brake; sweep restarts with a fresh prescaler
        turn_left = 1'b1;
        step(1);
        check("sw_left_first", 3'b001, 3'b000);
        step(4);
        check("sw_left_phase2", 3'b011, 3'b000);
        turn_left = 1'b0;
        turn_right = 1'b1;
        brake = 1'b1;
        step(1);
        check("sw_right_first", 3'b111, 3'b001);
        step(3);
        check("sw_right_hold", 3'b111, 3'b001);
        step(1);
        check("sw_right_step", 3'b111, 3'b011);
        turn_right = 1'b0;
        brake = 1'b0;
        step(1);
        check("sw_release", 3'b000, 3'b000);

        // 6. reset during hazard phase 3, restart after release
        hazard = 1'b1;
        step(1);
        check("rst_hz_first", 3'b001, 3'b001);
        step(8);
        check("rst_hz_phase3", 3'b111, 3'b111);
        rst_n = 1'b0;
        step(1);
        check("rst_hz_reset", 3'b000, 3'b000);
        rst_n = 1'b1;
        step(1);
        check("rst_hz_restart", 3'b001, 3'b001);
        step(3);
        check("rst_hz_hold", 3'b001, 3'b001);
        step(1);
        check("rst_hz_step", 3'b011, 3'b011);
        hazard = 1'b0;
        step(1);
        check("rst_hz_release", 3'b000, 3'b000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
